// File: rtl/full_subtractor_seq.sv
// full_subtractor_seq: ripple full subtractor computing a - b - bin, with an optional valid-tagged output register.
module full_subtractor_seq #(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             out_valid
);
    logic [WIDTH-1:0] d_c;
    logic             br;
    // Borrow ripples LSB to MSB; br ends up holding the borrow out of the top cell.
    always_comb begin
        d_c = '0;
        br  = bin;
        for (int k = 0; k < WIDTH; k++) begin
            d_c[k] = a[k] ^ b[k] ^ br;
            br     = (~a[k] & b[k]) | (~a[k] & br) | (b[k] & br);
        end
    end
    if (REGISTERED) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                d         <= '0;
                borrow    <= 1'b0;
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    d      <= d_c;
                    borrow <= br;
                end
            end
        end
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign d              = d_c;
        assign borrow         = br;
        assign out_valid      = in_valid;
    end
endmodule

// File: tb/tb_full_subtractor_seq.sv
// tb_full_subtractor_seq: checks combinational and registered subtractors against a table, directed vectors and a scoreboard.
module tb_full_subtractor_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a1, b1, bin1, d1, bo1, ov1;
    logic [3:0] a4, b4, d4;
    logic       bin4, bo4, ov4;
    logic [3:0] ra, rb, rd;
    logic       rbin, riv, rbo, rov;
    logic [7:0] a8, b8, d8, qd;
    logic       bin8, iv8, bo8, ov8, qbo, qov;

    full_subtractor_seq #(.WIDTH(1), .REGISTERED(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_valid(1'b1), .a(a1), .b(b1), .bin(bin1),
        .d(d1), .borrow(bo1), .out_valid(ov1));
    full_subtractor_seq #(.WIDTH(4), .REGISTERED(1'b0)) u4 (
        .clk(clk), .rst(rst), .in_valid(1'b1), .a(a4), .b(b4), .bin(bin4),
        .d(d4), .borrow(bo4), .out_valid(ov4));
    full_subtractor_seq #(.WIDTH(4), .REGISTERED(1'b1)) r4 (
        .clk(clk), .rst(rst), .in_valid(riv), .a(ra), .b(rb), .bin(rbin),
        .d(rd), .borrow(rbo), .out_valid(rov));
    full_subtractor_seq #(.WIDTH(8), .REGISTERED(1'b0)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .bin(bin8),
        .d(d8), .borrow(bo8), .out_valid(ov8));
    full_subtractor_seq #(.WIDTH(8), .REGISTERED(1'b1)) q8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .bin(bin8),
        .d(qd), .borrow(qbo), .out_valid(qov));

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else passed++;
    endtask

    logic [8:0] sb[$];
    logic [8:0] exp9, last;
    logic [7:0] d_tab  = 8'b1001_0110;
    logic [7:0] bo_tab = 8'b1000_1110;

    initial begin
        riv = 1'b0; ra = '0; rb = '0; rbin = 1'b0;
        iv8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        for (int n = 0; n < 8; n++) begin
            {a1, b1, bin1} = 3'(n);
            #1;
            check($sformatf("tt%0d_d", n), d1, d_tab[n]);
            check($sformatf("tt%0d_b", n), bo1, bo_tab[n]);
        end
        check("c1_ov", ov1, 1'b1);
        a4 = 4'h0; b4 = 4'h0; bin4 = 1'b1; #1;
        check("c4_under", {bo4, d4}, {1'b1, 4'hF});
        a4 = 4'h9; b4 = 4'h3; bin4 = 1'b0; #1;
        check("c4_96", {bo4, d4}, {1'b0, 4'h6});
        check("c4_ov", ov4, 1'b1);
        a8 = 8'h80; b8 = 8'h7F; bin8 = 1'b1; #1;
        check("c8_80", {bo8, d8}, {1'b0, 8'h00});
        a8 = 8'h10; b8 = 8'h10; bin8 = 1'b1; #1;
        check("c8_10", {bo8, d8}, {1'b1, 8'hFF});
        check("c8_ov", ov8, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_r4", {rov, rbo, rd}, 6'd0);
        check("rst_q8", {qov, qbo, qd}, 10'd0);
        rst = 1'b0; ra = 4'd5; rb = 4'd7; rbin = 1'b0; riv = 1'b1;
        @(posedge clk); #1;
        check("r4_57", {rov, rbo, rd}, {1'b1, 1'b1, 4'hE});
        riv = 1'b0; ra = 4'd3; rb = 4'd1;
        @(posedge clk); #1;
        check("r4_hold1", {rov, rbo, rd}, {1'b0, 1'b1, 4'hE});
        ra = 4'd0; rb = 4'hF; rbin = 1'b1;
        @(posedge clk); #1;
        check("r4_hold2", {rov, rbo, rd}, {1'b0, 1'b1, 4'hE});
        rst = 1'b1; riv = 1'b1; ra = 4'd9; rb = 4'd3; rbin = 1'b0;
        @(posedge clk); #1;
        check("r4_rstv", {rov, rbo, rd}, 6'd0);
        rst = 1'b0; riv = 1'b0;
        last = '0;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom_range(0, 1));
            iv8 = ($urandom_range(0, 3) != 0);
            exp9 = {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
            #1;
            check("c8_rand", {bo8, d8}, exp9);
            if (iv8) sb.push_back(exp9);
            @(posedge clk); #1;
            check("q8_ov", qov, iv8);
            if (qov) begin
                check("q8_sb", sb.size(), 1);
                if (sb.size() > 0) begin
                    last = sb.pop_front();
                    check("q8_rand", {qbo, qd}, last);
                end
            end else check("q8_hold", {qbo, qd}, last);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
